// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 target among several initiators.
// The winner keeps the bus for its whole CYC; an optional watchdog aborts a silent target.
module wishbone_rr_arbiter #(
    parameter int NumInitiators  = 2,
    parameter int AddressWidth   = 16,
    parameter int DataWidth      = 8,
    parameter int Granularity    = 8,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 0,
    localparam int SelWidth      = DataWidth / Granularity
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NumInitiators-1:0]              I_CYC,
    input  logic [NumInitiators-1:0]              I_STB,
    input  logic [NumInitiators-1:0]              I_WE,
    input  logic [NumInitiators-1:0]              I_LOCK,
    input  logic [NumInitiators*AddressWidth-1:0] I_ADDR,
    input  logic [NumInitiators*DataWidth-1:0]    I_DAT_W,
    input  logic [NumInitiators*SelWidth-1:0]     I_SEL,
    output logic [NumInitiators-1:0]              I_STALL,
    output logic [NumInitiators-1:0]              I_ACK,
    output logic [NumInitiators-1:0]              I_ERR,
    output logic [NumInitiators-1:0]              I_RTY,
    output logic [DataWidth-1:0]                  I_DAT_R,
    output logic                                  T_CYC,
    output logic                                  T_STB,
    output logic                                  T_WE,
    output logic                                  T_LOCK,
    output logic [AddressWidth-1:0]               T_ADDR,
    output logic [DataWidth-1:0]                  T_DAT_W,
    output logic [SelWidth-1:0]                   T_SEL,
    input  logic                                  T_STALL,
    input  logic                                  T_ACK,
    input  logic                                  T_ERR,
    input  logic                                  T_RTY,
    input  logic [DataWidth-1:0]                  T_DAT_R
);

    localparam int GrantWidth = $clog2(NumInitiators);
    localparam int SumWidth   = GrantWidth + 1;
    localparam int CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic [1:0]            r_state;
    logic [GrantWidth-1:0] r_grant;
    logic [GrantWidth-1:0] r_ptr;
    logic [CntWidth-1:0]   r_outst;
    logic [TimerWidth-1:0] r_timer;

    logic [AddressWidth-1:0] w_addr_arr [NumInitiators];
    logic [DataWidth-1:0]    w_datw_arr [NumInitiators];
    logic [SelWidth-1:0]     w_sel_arr  [NumInitiators];
    logic [GrantWidth-1:0]   w_chain    [NumInitiators+1];

    logic [NumInitiators-1:0] w_rot;
    logic [NumInitiators-1:0] w_sel;
    logic [GrantWidth-1:0]    w_winner;
    logic [GrantWidth-1:0]    w_ptr_inc;
    logic [CntWidth-1:0]      w_outst_nxt;
    logic [TimerWidth-1:0]    w_timer_nxt;
    logic                     w_any;
    logic                     w_owned;
    logic                     w_cyc_g;
    logic                     w_stb_g;
    logic                     w_we_g;
    logic                     w_lock_g;
    logic                     w_full;
    logic                     w_accept;
    logic                     w_term;
    logic                     w_timeout;

    // Request vector rotated so bit 0 is the initiator at the pointer.
    assign w_rot = NumInitiators'({I_CYC, I_CYC} >> r_ptr);
    assign w_any = |I_CYC;
    assign w_chain[NumInitiators] = '0;

    for (genvar i = 0; i < NumInitiators; i++) begin : g_slice
        logic [SumWidth-1:0] w_sum;

        assign w_addr_arr[i] = I_ADDR[i*AddressWidth +: AddressWidth];
        assign w_datw_arr[i] = I_DAT_W[i*DataWidth +: DataWidth];
        assign w_sel_arr[i]  = I_SEL[i*SelWidth +: SelWidth];

        // Lowest rotated position wins; w_sum maps it back to an absolute index.
        assign w_sum      = SumWidth'(r_ptr) + SumWidth'(i);
        assign w_chain[i] = w_rot[i]
                          ? GrantWidth'((w_sum >= SumWidth'(NumInitiators))
                                        ? w_sum - SumWidth'(NumInitiators) : w_sum)
                          : w_chain[i+1];

        assign w_sel[i]   = w_owned & (r_grant == GrantWidth'(i));
        assign I_STALL[i] = ~w_sel[i] | T_STALL | w_full;
        assign I_ACK[i]   = w_sel[i] & T_ACK;
        assign I_ERR[i]   = w_sel[i] & (T_ERR | w_timeout);
        assign I_RTY[i]   = w_sel[i] & T_RTY;
    end

    assign w_winner  = w_chain[0];
    assign w_ptr_inc = (r_grant == GrantWidth'(NumInitiators - 1)) ? '0
                     : r_grant + GrantWidth'(1);

    assign w_owned  = (r_state == ST_OWNED);
    assign w_cyc_g  = I_CYC[r_grant];
    assign w_stb_g  = I_STB[r_grant];
    assign w_we_g   = I_WE[r_grant];
    assign w_lock_g = I_LOCK[r_grant];
    assign w_full   = (r_outst == CntWidth'(MaxOutstanding));

    assign T_CYC   = w_owned & w_cyc_g;
    assign T_STB   = w_owned & w_stb_g & ~w_full;
    assign T_WE    = w_owned & w_we_g;
    assign T_LOCK  = w_owned & w_lock_g;
    assign T_ADDR  = w_owned ? w_addr_arr[r_grant] : '0;
    assign T_DAT_W = w_owned ? w_datw_arr[r_grant] : '0;
    assign T_SEL   = w_owned ? w_sel_arr[r_grant]  : '0;
    assign I_DAT_R = T_DAT_R;

    assign w_accept = T_STB & ~T_STALL;
    assign w_term   = w_owned & (T_ACK | T_ERR | T_RTY);

    // Fires in the cycle the silent count reaches its limit; the error pulse is this cycle.
    assign w_timeout = (TimeoutCycles > 0) && w_owned && w_cyc_g && (r_outst != '0)
                    && !w_term && !w_accept
                    && (r_timer == TimerWidth'(TimeoutCycles - 1));

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_accept && !(w_term && r_outst != '0))
            w_outst_nxt = r_outst + CntWidth'(1);
        else if (!w_accept && w_term && r_outst != '0)
            w_outst_nxt = r_outst - CntWidth'(1);
    end

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_accept || w_term)
            w_timer_nxt = '0;
        else if (r_outst != '0)
            w_timer_nxt = r_timer + TimerWidth'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_outst <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_OWNED;
                        r_grant <= w_winner;
                        r_outst <= '0;
                        r_timer <= '0;
                    end
                end
                ST_OWNED: begin
                    if (!w_cyc_g) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_inc;
                        r_outst <= '0;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_ABORT;
                        r_outst <= '0;
                        r_timer <= '0;
                    end else begin
                        r_outst <= w_outst_nxt;
                        r_timer <= w_timer_nxt;
                    end
                end
                ST_ABORT: begin
                    if (!w_cyc_g) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench: a cycle-level reference model queues the expected bus outputs,
// and a negedge monitor pops and compares them against the arbiter.
module tb_wishbone_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int G    = 8;
    localparam int SW   = DW / G;
    localparam int MAXO = 2;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    cyc = '0, stb = '0, we = '0, lock = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] datw = '0;
    logic [N*SW-1:0] sel = '0;
    logic            t_stall = 1'b0, t_ack = 1'b0, t_err = 1'b0, t_rty = 1'b0;
    logic [DW-1:0]   t_dat_r = 8'h5A;

    logic [N-1:0]    istall, iack, ierr, irty;
    logic [DW-1:0]   idatr;
    logic            tcyc, tstb, twe, tlock;
    logic [AW-1:0]   taddr;
    logic [DW-1:0]   tdatw;
    logic [SW-1:0]   tsel;

    wishbone_rr_arbiter #(
        .NumInitiators(N), .AddressWidth(AW), .DataWidth(DW), .Granularity(G),
        .MaxOutstanding(MAXO), .TimeoutCycles(TO)
    ) dut (
        .CLK(clk), .RST(rst),
        .I_CYC(cyc), .I_STB(stb), .I_WE(we), .I_LOCK(lock),
        .I_ADDR(addr), .I_DAT_W(datw), .I_SEL(sel),
        .I_STALL(istall), .I_ACK(iack), .I_ERR(ierr), .I_RTY(irty), .I_DAT_R(idatr),
        .T_CYC(tcyc), .T_STB(tstb), .T_WE(twe), .T_LOCK(tlock),
        .T_ADDR(taddr), .T_DAT_W(tdatw), .T_SEL(tsel),
        .T_STALL(t_stall), .T_ACK(t_ack), .T_ERR(t_err), .T_RTY(t_rty), .T_DAT_R(t_dat_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            chk;
        logic          tcyc, tstb, twe, tlock;
        logic [AW-1:0] taddr;
        logic [DW-1:0] tdatw, idatr;
        logic [SW-1:0] tsel;
        logic [N-1:0]  stall, ack, err, rty;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: owner -1 means nobody holds the bus.
    int m_owner  = -1;
    bit m_abort  = 0;
    int m_ptr    = 0;
    int m_out    = 0;
    int m_silent = 0;

    int grants[$];
    bit cap_en   = 0;
    bit prev_cyc = 0;
    bit err_en   = 0;
    int err_seen = 0;

    function automatic bit bit_at(logic [N-1:0] v, int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        return N'(1) << i;
    endfunction

    task automatic model_step();
        exp_t e;
        int   g, nk;
        bit   term, acc, tmo, full;
        e       = '{default: '0};
        e.stall = '1;
        e.idatr = t_dat_r;
        if (!rst) begin
            e.chk = 1;
            m_owner = -1; m_abort = 0; m_ptr = 0; m_out = 0; m_silent = 0;
        end else if (m_owner < 0) begin
            nk = -1;
            for (int i = 0; i < N; i++)
                if (nk < 0 && bit_at(cyc, (m_ptr + i) % N)) nk = (m_ptr + i) % N;
            if (nk >= 0) begin
                m_owner = nk; m_abort = 0; m_out = 0; m_silent = 0;
            end
        end else if (m_abort) begin
            if (!bit_at(cyc, m_owner)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            g      = m_owner;
            full   = (m_out == MAXO);
            e.chk  = 1;
            e.tcyc = bit_at(cyc, g);
            e.tstb = bit_at(stb, g) && !full;
            e.twe  = bit_at(we, g);
            e.tlock = bit_at(lock, g);
            e.taddr = AW'(addr >> (g * AW));
            e.tdatw = DW'(datw >> (g * DW));
            e.tsel  = SW'(sel >> (g * SW));
            if (!(t_stall || full)) e.stall = ~onehot(g);
            if (t_ack) e.ack = onehot(g);
            if (t_err) e.err = onehot(g);
            if (t_rty) e.rty = onehot(g);
            term = t_ack || t_err || t_rty;
            acc  = e.tstb && !t_stall;
            tmo  = (TO > 0) && e.tcyc && (m_out > 0) && !term && !acc && (m_silent == TO - 1);
            if (tmo) e.err = onehot(g);
            if (!e.tcyc) begin
                m_owner = -1;
                m_ptr   = (g + 1) % N;
            end else if (tmo) begin
                m_abort = 1; m_out = 0; m_silent = 0;
            end else begin
                if (acc || term) m_silent = 0;
                else if (m_out > 0) m_silent++;
                if (term && m_out > 0) m_out--;
                if (acc) m_out++;
            end
        end
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(string name, int got, int want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                bad = (tcyc !== e.tcyc) || (tstb !== e.tstb) || (istall !== e.stall) ||
                      (iack !== e.ack) || (ierr !== e.err) || (irty !== e.rty) ||
                      (idatr !== e.idatr);
                if (e.chk)
                    bad = bad || (twe !== e.twe) || (tlock !== e.tlock) || (taddr !== e.taddr) ||
                          (tdatw !== e.tdatw) || (tsel !== e.tsel);
                n_checks++;
                if (bad) begin
                    n_err++;
                    if (n_err <= 30)
                        $display("FAIL bus_cycle t=%0t got cyc=%b stb=%b stall=%b ack=%b err=%b rty=%b we=%b lk=%b addr=%h wd=%h sel=%b rd=%h | want cyc=%b stb=%b stall=%b ack=%b err=%b rty=%b we=%b lk=%b addr=%h wd=%h sel=%b rd=%h",
                                 $time, tcyc, tstb, istall, iack, ierr, irty, twe, tlock, taddr, tdatw, tsel, idatr,
                                 e.tcyc, e.tstb, e.stall, e.ack, e.err, e.rty, e.twe, e.tlock, e.taddr, e.tdatw, e.tsel, e.idatr);
                end
            end
            if (cap_en && tcyc === 1'b1 && !prev_cyc) grants.push_back(int'(taddr[3:0]));
            prev_cyc = (tcyc === 1'b1);
            if (err_en) err_seen += $countones(ierr);
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int want_a[5];
        int quiet;
        int r;
        want_a = '{0, 1, 2, 3, 0};
        quiet  = 0;
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = AW'(16'hA000 + k);
        @(posedge clk);
        #1;

        // Reset held with every initiator requesting, then released.
        cyc = '1;
        repeat (3) tick();
        grants.delete();
        cap_en = 1;
        rst = 1'b1;
        tick();

        // Four back-to-back rounds: one request, one ACK, release, re-request.
        for (int g = 0; g < N; g++) begin
            stb = onehot(g);
            tick();
            stb   = '0;
            t_ack = 1'b1;
            tick();
            t_ack = 1'b0;
            cyc   = cyc & ~onehot(g);
            tick();
            cyc = '1;
            tick();
        end
        tick();
        cap_en = 0;
        check_int("grant_count", grants.size(), 5);
        for (int i = 0; i < 5; i++)
            check_int("grant_order", (i < grants.size()) ? grants[i] : -1, want_a[i]);

        // Outstanding limit on initiator 0.
        cyc = 4'b0001;
        stb = 4'b0001;
        repeat (3) tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        tick();
        stb = '0;
        tick();
        cyc = '0;
        tick();

        // Initiator 1 owns while initiator 2 waits with CYC+STB.
        cyc = 4'b0110;
        stb = 4'b0100;
        tick();
        stb = 4'b0110;
        tick();
        stb   = 4'b0100;
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        tick();
        cyc = 4'b0100;
        tick();

        // Initiator 2: one accepted request, silent target, watchdog abort.
        err_seen = 0;
        err_en   = 1;
        tick();
        tick();
        stb = '0;
        repeat (12) tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        cyc   = '0;
        tick();
        tick();
        err_en = 0;
        check_int("watchdog_err_pulses", err_seen, 1);

        // Release with two outstanding, late ACK in the idle cycle, next grant wraps to 0.
        grants.delete();
        cap_en = 1;
        cyc = 4'b1000;
        stb = 4'b1000;
        repeat (3) tick();
        stb   = '0;
        cyc   = '0;
        tick();
        cyc   = 4'b1001;
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        tick();
        cap_en = 0;
        check_int("wrap_grant_count", grants.size(), 2);
        check_int("wrap_grant_first", (grants.size() > 0) ? grants[0] : -1, 3);
        check_int("wrap_grant_next", (grants.size() > 1) ? grants[1] : -1, 0);
        cyc = '0;
        tick();
        tick();

        // Randomized traffic with quiet windows long enough to trip the watchdog.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) rst = 1'b0;
            if (i == 2002) rst = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (bit_at(cyc, k)) begin
                    if ($urandom_range(0, 11) == 0) cyc = cyc & ~onehot(k);
                end else if ($urandom_range(0, 5) == 0) begin
                    cyc = cyc | onehot(k);
                end
                addr[k*AW +: AW] = AW'($urandom);
                datw[k*DW +: DW] = DW'($urandom);
            end
            stb  = N'($urandom);
            we   = N'($urandom);
            lock = N'($urandom);
            sel  = (N*SW)'($urandom);
            t_stall = ($urandom_range(0, 3) == 0);
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 39) == 0) quiet = 14;
            r = $urandom_range(0, 99);
            t_ack   = (quiet == 0) && (r < 30);
            t_err   = (quiet == 0) && (r >= 30) && (r < 35);
            t_rty   = (quiet == 0) && (r >= 35) && (r < 40);
            t_dat_r = DW'($urandom);
            tick();
        end

        cyc = '0; stb = '0;
        t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        check_int("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
